// File: rtl/mult8_pkg.sv
// -----------------------------------------------------------------------------
// mult8_pkg
// Shared definitions for the sequential 8x8 shift-and-add multiplier:
//   - FSM state encoding (state_e)
//   - datapath width W and iteration-counter width/limit
// -----------------------------------------------------------------------------
package mult8_pkg;

   localparam int W     = 8;
   localparam int CNT_W = 3;

   localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

   // 2'd3 is unused; the FSM steers it back to ST_IDLE on the next edge.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : mult8_pkg

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
//   A, B  in  8  operands
//   CI    in  1  carry in
//   Y     out 8  sum
//   CO    out 1  carry out of bit 7
//   V     out 1  signed overflow
//   N     out 1  sign of the sum (Y[7])
//   Z     out 1  sum is zero
// -----------------------------------------------------------------------------
module adder
   import mult8_pkg::*;
(
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         CI,
   output logic [W-1:0] Y,
   output logic         CO,
   output logic         V,
   output logic         N,
   output logic         Z
);

   logic [W-1:0] gen;
   logic [W-1:0] prop;
   logic [W:0]   carry;

   // Group generate/propagate for each 4-bit block
   logic         grp_g_lo;
   logic         grp_p_lo;
   logic         grp_g_hi;
   logic         grp_p_hi;

   assign gen  = A & B;
   assign prop = A ^ B;

   assign grp_g_lo = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                   | (prop[3] & prop[2] & prop[1] & gen[0]);
   assign grp_p_lo = &prop[3:0];
   assign grp_g_hi = gen[7] | (prop[7] & gen[6]) | (prop[7] & prop[6] & gen[5])
                   | (prop[7] & prop[6] & prop[5] & gen[4]);
   assign grp_p_hi = &prop[7:4];

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      carry    = '0;
      carry[0] = CI;
      // Block carry-ins come from lookahead, not from rippling across blocks
      carry[4] = grp_g_lo | (grp_p_lo & CI);
      carry[8] = grp_g_hi | (grp_p_hi & carry[4]);
      // Carries inside each block, fully expanded from the block carry-in
      carry[1] = gen[0] | (prop[0] & carry[0]);
      carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry[0]);
      carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
               | (prop[2] & prop[1] & prop[0] & carry[0]);
      carry[5] = gen[4] | (prop[4] & carry[4]);
      carry[6] = gen[5] | (prop[5] & gen[4]) | (prop[5] & prop[4] & carry[4]);
      carry[7] = gen[6] | (prop[6] & gen[5]) | (prop[6] & prop[5] & gen[4])
               | (prop[6] & prop[5] & prop[4] & carry[4]);
   end

   assign Y  = prop ^ carry[W-1:0];
   assign CO = carry[W];
   assign V  = carry[W] ^ carry[W-1];
   assign N  = Y[W-1];
   assign Z  = (Y == '0);

endmodule : adder

// File: rtl/mult8_seq.sv
// -----------------------------------------------------------------------------
// mult8_seq
// Sequential 8x8 unsigned shift-and-add multiplier, 16-bit product.
// One multiply takes 9 cycles from the accepting edge to the DONE cycle.
//   CLK    in  1   clock, rising edge
//   RST_N  in  1   asynchronous active-low reset
//   START  in  1   request; accepted only in IDLE or DONE
//   A      in  8   multiplicand, captured on accepted START
//   B      in  8   multiplier, captured on accepted START
//   P      out 16  last completed product
//   BUSY   out 1   high while iterating
//   DONE   out 1   one-cycle pulse when P has just been updated
//   Z      out 1   P == 0
//   HI_NZ  out 1   product does not fit in 8 bits
// -----------------------------------------------------------------------------
module mult8_seq
   import mult8_pkg::*;
(
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           START,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   output logic [2*W-1:0] P,
   output logic           BUSY,
   output logic           DONE,
   output logic           Z,
   output logic           HI_NZ
);

   state_e               state_q,  state_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic [W-1:0]         m_q,      m_d;   // multiplicand
   logic [W-1:0]         h_q,      h_d;   // upper half of partial product
   logic [W-1:0]         l_q,      l_d;   // lower half / remaining multiplier bits
   logic [2*W-1:0]       p_q,      p_d;
   logic                 busy_q,   busy_d;
   logic                 done_q,   done_d;

   logic [W-1:0]         add_y;
   logic                 add_co;
   logic                 add_v;
   logic                 add_n;
   logic                 add_z;
   logic [2*W-1:0]       shift_hl;

   adder u_adder (
      .A  (h_q),
      .B  (m_q),
      .CI (1'b0),
      .Y  (add_y),
      .CO (add_co),
      .V  (add_v),
      .N  (add_n),
      .Z  (add_z)
   );

   // Overflow, sign and zero flags of the adder have no role in multiplication
   logic unused_adder_flags;
   assign unused_adder_flags = add_v ^ add_n ^ add_z;

   // One iteration: conditionally add M into H, then shift {carry, H, L} right
   assign shift_hl = l_q[0] ? {add_co, add_y, l_q[W-1:1]}
                            : {1'b0,   h_q,   l_q[W-1:1]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      h_d     = h_q;
      l_d     = l_q;
      p_d     = p_q;

      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_RUN;
               m_d     = A;
               h_d     = '0;
               l_d     = B;
               cnt_d   = '0;
            end
         end

         ST_RUN: begin
            {h_d, l_d} = shift_hl;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               p_d     = shift_hl;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DONE: begin
            if (START) begin
               state_d = ST_RUN;
               m_d     = A;
               h_d     = '0;
               l_d     = B;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Flags are registered from the next state so they line up with state_q
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         m_q     <= '0;
         h_q     <= '0;
         l_q     <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         h_q     <= h_d;
         l_q     <= l_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign P     = p_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign Z     = (p_q == '0);
   assign HI_NZ = |p_q[2*W-1:W];

endmodule : mult8_seq

// File: tb/tb_mult8_seq.sv
// -----------------------------------------------------------------------------
// tb_mult8_seq
// Self-checking bench for mult8_seq. Expected products come from plain
// multiplication; expected timing comes from the 9-cycle handshake rules.
// -----------------------------------------------------------------------------
module tb_mult8_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] p;
   logic        busy;
   logic        done;
   logic        z;
   logic        hi_nz;

   int          n_vec;
   int          n_err;
   logic [15:0] last_p;   // product the DUT should be holding between results

   mult8_seq dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .START (start),
      .A     (a),
      .B     (b),
      .P     (p),
      .BUSY  (busy),
      .DONE  (done),
      .Z     (z),
      .HI_NZ (hi_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Product plus its derived flags
   task automatic check_p(input string tag, input logic [15:0] exp_p);
      check({tag, ".P"},     p,             exp_p);
      check({tag, ".Z"},     16'(z),        16'(exp_p == 16'h0));
      check({tag, ".HI_NZ"}, 16'(hi_nz),    16'(exp_p[15:8] != 8'h0));
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".BUSY"}, 16'(busy), 16'd0);
      check({tag, ".DONE"}, 16'(done), 16'd0);
      check_p(tag, 16'h0000);
   endtask

   // One START pulse, then walk the 9-cycle window. With poke set, a second
   // START with other operands arrives in RUN cycle 3 and must be ignored.
   task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input bit poke);
      logic [15:0] exp_p;
      exp_p = 16'(op_a) * 16'(op_b);
      @(negedge clk);
      start = 1'b1;
      a     = op_a;
      b     = op_b;
      @(negedge clk);                     // accepting edge e0 has passed
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check("run.BUSY", 16'(busy), 16'd1);
         check("run.DONE", 16'(done), 16'd0);
         check("run.P",    p,         last_p);
         start = poke && (k == 3);
         a     = 8'($urandom);
         b     = 8'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      check("done.BUSY", 16'(busy), 16'd0);
      check("done.DONE", 16'(done), 16'd1);
      check_p("done", exp_p);
      last_p = exp_p;
      @(negedge clk);
      check("idle.BUSY", 16'(busy), 16'd0);
      check("idle.DONE", 16'(done), 16'd0);
      check("idle.P",    p,         last_p);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      last_p = 16'h0000;
      rst_n  = 1'b0;
      start  = 1'b0;
      a      = 8'h00;
      b      = 8'h00;

      #12;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      run_op(8'h0F, 8'h0F, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b0);
      run_op(8'h00, 8'h5A, 1'b0);
      run_op(8'h5A, 8'h01, 1'b0);
      run_op(8'h21, 8'h13, 1'b1);

      // Asynchronous reset in RUN cycle 5
      @(negedge clk);
      start = 1'b1;
      a     = 8'h5A;
      b     = 8'h33;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < 5; k++) @(negedge clk);
      check("pre_rst.BUSY", 16'(busy), 16'd1);
      rst_n = 1'b0;
      #1;
      check_reset("mid_rst");
      last_p = 16'h0000;
      @(negedge clk);
      check_reset("mid_rst_hold");
      rst_n = 1'b1;
      run_op(8'h03, 8'h07, 1'b0);

      // START held high: second operands accepted in the DONE cycle
      @(negedge clk);
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h10;
      @(negedge clk);
      a = 8'h02;
      b = 8'h80;
      for (int k = 1; k <= 18; k++) begin
         check("b2b.BUSY", 16'(busy), 16'((k != 9) && (k != 18)));
         check("b2b.DONE", 16'(done), 16'((k == 9) || (k == 18)));
         if (k == 9 || k == 18) begin
            check_p("b2b", 16'h0100);
            last_p = 16'h0100;
         end else begin
            check("b2b.P_hold", p, last_p);
         end
         if (k == 18) start = 1'b0;
         @(negedge clk);
      end
      check("b2b_end.BUSY", 16'(busy), 16'd0);
      check("b2b_end.DONE", 16'(done), 16'd0);

      // Randomized operands, random pokes and idle gaps
      repeat (24) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard stop in case the stimulus process ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mult8_seq
